alu16_seq32: RTL and testbench

Sequencer that runs 32-bit operations on the existing 16-bit 74181-based ALU (alu16) by making two passes: low word, then high word.
- The carry out of the low pass feeds the carry in of the high pass.
- Requests arrive on a valid/ready command channel; results return on a valid/ready response channel.
- Sits between a requester (CPU or test driver) and a single alu16 instance. This block owns all alu16 inputs.

---
 rtl/alu16_pkg.sv | 75 +++++++
 rtl/alu16_seq32_if.sv | 32 +++
 rtl/alu16.sv | 83 ++++++++
 rtl/alu16_seq32.sv | 124 ++++++++++++
 tb/tb_alu16_seq32.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu16_pkg
// Description : Shared types and 74181 control constants for the alu16
//               32-bit sequencer. Also holds the op -> (mode, sel, cin)
//               decode used for both ALU passes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu16_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_e;

  // 74181 function selects, active-high data convention
  localparam logic [3:0] SEL_ADD  = 4'b1001;  // M=0: A plus B
  localparam logic [3:0] SEL_SUB  = 4'b0110;  // M=0: A minus B minus 1
  localparam logic [3:0] SEL_AND  = 4'b1011;  // M=1: A and B
  localparam logic [3:0] SEL_XOR  = 4'b0110;  // M=1: A xor B
  localparam logic [3:0] SEL_IDLE = 4'b0000;

  typedef struct packed {
    logic       mode;
    logic [3:0] sel;
    logic       cin;   // logical (active-high) carry in
  } alu_ctl_t;

  function automatic logic alu16_is_logic(input op_e op);
    return (op == OP_AND) || (op == OP_XOR);
  endfunction

  // Control word for one pass. The high pass of ADD/SUB chains the low-pass
  // carry; SUB's low pass injects 1 to turn A-B-1 into A-B.
  function automatic alu_ctl_t alu16_decode(input op_e op, input logic hi_pass,
                                            input logic c_lo);
    alu_ctl_t ctl;
    ctl.mode = 1'b1;
    ctl.sel  = SEL_IDLE;
    ctl.cin  = 1'b0;
    case (op)
      OP_ADD: begin
        ctl.mode = 1'b0;
        ctl.sel  = SEL_ADD;
        ctl.cin  = hi_pass ? c_lo : 1'b0;
      end
      OP_SUB: begin
        ctl.mode = 1'b0;
        ctl.sel  = SEL_SUB;
        ctl.cin  = hi_pass ? c_lo : 1'b1;
      end
      OP_AND: begin
        ctl.mode = 1'b1;
        ctl.sel  = SEL_AND;
      end
      OP_XOR: begin
        ctl.mode = 1'b1;
        ctl.sel  = SEL_XOR;
      end
      default: ;
    endcase
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu16_seq32_if.sv
`default_nettype none
// ============================================================================
// Module      : alu16_seq32_if
// Description : Command/response channel between a requester and the
//               alu16_seq32 sequencer.
//               req_*: valid/ready command (op, a, b)
//               rsp_*: valid/ready response (result, carry, zero)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu16_seq32_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu16.sv
`default_nettype none
// ============================================================================
// Module      : alu16
// Description : 16-bit 74181-style ALU (four cascaded slices, behavioural).
//               Ports: a, b (data), mode (M), sel (S3..S0), cin/cout
//               (physical carry pins, active-low when CARRY_ACTIVE_LOW=1),
//               result (F).
//               Cout follows the arithmetic sum of the selected function even
//               in logic mode, as the real part's carry lookahead does.
// Revision    : 1.0 - initial release
// ============================================================================
module alu16 #(
  parameter bit CARRY_ACTIVE_LOW = 1'b1
) (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  input  wire logic        mode,
  input  wire logic [3:0]  sel,
  input  wire logic        cin,
  output logic      [15:0] result,
  output logic             cout
);

  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_logic;
  logic [16:0] w_sum;
  logic        w_cin;

  assign w_cin = cin ^ CARRY_ACTIVE_LOW;

  // Arithmetic functions as F = x + y + cin ("minus 1" is + 16'hFFFF)
  always_comb begin
    w_x = a;
    w_y = 16'h0000;
    case (sel)
      4'b0000: begin w_x = a;        w_y = 16'h0000; end
      4'b0001: begin w_x = a | b;    w_y = 16'h0000; end
      4'b0010: begin w_x = a | ~b;   w_y = 16'h0000; end
      4'b0011: begin w_x = 16'hFFFF; w_y = 16'h0000; end
      4'b0100: begin w_x = a;        w_y = a & ~b;   end
      4'b0101: begin w_x = a | b;    w_y = a & ~b;   end
      4'b0110: begin w_x = a;        w_y = ~b;       end
      4'b0111: begin w_x = a & ~b;   w_y = 16'hFFFF; end
      4'b1000: begin w_x = a;        w_y = a & b;    end
      4'b1001: begin w_x = a;        w_y = b;        end
      4'b1010: begin w_x = a | ~b;   w_y = a & b;    end
      4'b1011: begin w_x = a & b;    w_y = 16'hFFFF; end
      4'b1100: begin w_x = a;        w_y = a;        end
      4'b1101: begin w_x = a | b;    w_y = a;        end
      4'b1110: begin w_x = a | ~b;   w_y = a;        end
      default: begin w_x = a;        w_y = 16'hFFFF; end
    endcase
  end

  always_comb begin
    w_logic = 16'h0000;
    case (sel)
      4'b0000: w_logic = ~a;
      4'b0001: w_logic = ~(a | b);
      4'b0010: w_logic = ~a & b;
      4'b0011: w_logic = 16'h0000;
      4'b0100: w_logic = ~(a & b);
      4'b0101: w_logic = ~b;
      4'b0110: w_logic = a ^ b;
      4'b0111: w_logic = a & ~b;
      4'b1000: w_logic = ~a | b;
      4'b1001: w_logic = ~(a ^ b);
      4'b1010: w_logic = b;
      4'b1011: w_logic = a & b;
      4'b1100: w_logic = 16'hFFFF;
      4'b1101: w_logic = a | ~b;
      4'b1110: w_logic = a | b;
      default: w_logic = a;
    endcase
  end

  assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + {16'h0000, w_cin};
  assign result = mode ? w_logic : w_sum[15:0];
  assign cout   = w_sum[16] ^ CARRY_ACTIVE_LOW;

endmodule
`default_nettype wire

// File: rtl/alu16_seq32.sv
`default_nettype none
// ============================================================================
// Module      : alu16_seq32
// Description : Runs 32-bit ADD/SUB/AND/XOR on a single 16-bit 74181-based
//               alu16 in two passes (low word, then high word), chaining the
//               low-pass carry into the high pass.
//               Ports: clk, rst (async active-high)
//                      bus    : command/response channel (slave side)
//                      alu_*  : drives every alu16 input, reads result/cout
// Revision    : 1.0 - initial release
// ============================================================================
module alu16_seq32
  import alu16_pkg::*;
#(
  parameter bit CARRY_ACTIVE_LOW = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu16_seq32_if.slave     bus,
  output logic      [15:0] alu_a,
  output logic      [15:0] alu_b,
  output logic             alu_mode,
  output logic      [3:0]  alu_sel,
  output logic             alu_cin,
  input  wire logic [15:0] alu_result,
  input  wire logic        alu_cout
);

  state_e      r_state;
  state_e      w_state_nxt;
  op_e         r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [15:0] r_res_lo;
  logic        r_c_lo;
  logic [31:0] r_result;
  logic        r_carry;
  logic        r_zero;

  alu_ctl_t    w_ctl;
  logic        w_cout_log;
  logic [31:0] w_full;

  assign w_ctl      = alu16_decode(r_op, (r_state == HI), r_c_lo);
  assign w_cout_log = alu_cout ^ CARRY_ACTIVE_LOW;
  assign w_full     = {alu_result, r_res_lo};

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_result = r_result;
  assign bus.rsp_carry  = r_carry;
  assign bus.rsp_zero   = r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus ALU drive. Outside LO/HI the ALU sees a fixed, X-free
  // idle pattern with the carry pin at its logical-0 level.
  always_comb begin
    w_state_nxt = r_state;
    alu_a       = 16'h0000;
    alu_b       = 16'h0000;
    alu_mode    = 1'b1;
    alu_sel     = SEL_IDLE;
    alu_cin     = CARRY_ACTIVE_LOW;
    case (r_state)
      IDLE: if (bus.req_valid) w_state_nxt = LO;
      LO: begin
        alu_a       = r_a[15:0];
        alu_b       = r_b[15:0];
        alu_mode    = w_ctl.mode;
        alu_sel     = w_ctl.sel;
        alu_cin     = w_ctl.cin ^ CARRY_ACTIVE_LOW;
        w_state_nxt = HI;
      end
      HI: begin
        alu_a       = r_a[31:16];
        alu_b       = r_b[31:16];
        alu_mode    = w_ctl.mode;
        alu_sel     = w_ctl.sel;
        alu_cin     = w_ctl.cin ^ CARRY_ACTIVE_LOW;
        w_state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_res_lo <= 16'h0;
      r_c_lo   <= 1'b0;
      r_result <= 32'h0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_op <= op_e'(bus.req_op);
          r_a  <= bus.req_a;
          r_b  <= bus.req_b;
        end
        LO: begin
          r_res_lo <= alu_result;
          r_c_lo   <= w_cout_log;
        end
        HI: begin
          r_result <= w_full;
          r_zero   <= (w_full == 32'h0);
          // The 74181 still drives Cout in logic mode; it is meaningless there
          r_carry  <= alu16_is_logic(r_op) ? 1'b0 : w_cout_log;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu16_seq32.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu16_seq32
// Description : Directed self-checking bench. Two sequencer+alu16 pairs run
//               side by side, one with active-low carry pins and one with
//               active-high pins; both must give identical results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu16_seq32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu16_seq32_if ifl ();
  alu16_seq32_if ifh ();

  logic [15:0] la_a, la_b, la_res, ha_a, ha_b, ha_res;
  logic [3:0]  la_sel, ha_sel;
  logic        la_mode, la_cin, la_cout, ha_mode, ha_cin, ha_cout;

  alu16_seq32 #(.CARRY_ACTIVE_LOW(1'b1)) u_seq_l (
    .clk(clk), .rst(rst), .bus(ifl),
    .alu_a(la_a), .alu_b(la_b), .alu_mode(la_mode), .alu_sel(la_sel),
    .alu_cin(la_cin), .alu_result(la_res), .alu_cout(la_cout)
  );
  alu16 #(.CARRY_ACTIVE_LOW(1'b1)) u_alu_l (
    .a(la_a), .b(la_b), .mode(la_mode), .sel(la_sel), .cin(la_cin),
    .result(la_res), .cout(la_cout)
  );

  alu16_seq32 #(.CARRY_ACTIVE_LOW(1'b0)) u_seq_h (
    .clk(clk), .rst(rst), .bus(ifh),
    .alu_a(ha_a), .alu_b(ha_b), .alu_mode(ha_mode), .alu_sel(ha_sel),
    .alu_cin(ha_cin), .alu_result(ha_res), .alu_cout(ha_cout)
  );
  alu16 #(.CARRY_ACTIVE_LOW(1'b0)) u_alu_h (
    .a(ha_a), .b(ha_b), .mode(ha_mode), .sel(ha_sel), .cin(ha_cin),
    .result(ha_res), .cout(ha_cout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    ifl.req_valid = v; ifl.req_op = op; ifl.req_a = a; ifl.req_b = b;
    ifh.req_valid = v; ifh.req_op = op; ifh.req_a = a; ifh.req_b = b;
  endtask

  task automatic set_rsp_ready(input logic r);
    ifl.rsp_ready = r;
    ifh.rsp_ready = r;
  endtask

  // Issue at a negedge, wait for the response, check latency and payload.
  task automatic issue_and_wait(input string tag, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
    int lat;
    @(negedge clk);
    check({tag, "_req_ready_l"}, {31'b0, ifl.req_ready}, 32'd1);
    check({tag, "_req_ready_h"}, {31'b0, ifh.req_ready}, 32'd1);
    set_req(1'b1, op, a, b);
    @(posedge clk);
    #1;
    // Scramble operands: the sequencer must work from its latched copy
    set_req(1'b0, 2'd3, 32'hDEADBEEF, 32'h01234567);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (ifl.rsp_valid) break;
    end
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_valid_h"}, {31'b0, ifh.rsp_valid}, 32'd1);
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] res,
                           input logic carry, input logic zero);
    check({tag, "_res_l"},   ifl.rsp_result, res);
    check({tag, "_res_h"},   ifh.rsp_result, res);
    check({tag, "_carry_l"}, {31'b0, ifl.rsp_carry}, {31'b0, carry});
    check({tag, "_carry_h"}, {31'b0, ifh.rsp_carry}, {31'b0, carry});
    check({tag, "_zero_l"},  {31'b0, ifl.rsp_zero},  {31'b0, zero});
    check({tag, "_zero_h"},  {31'b0, ifh.rsp_zero},  {31'b0, zero});
  endtask

  task automatic handshake(input string tag);
    set_rsp_ready(1'b1);
    @(posedge clk);
    #1;
    set_rsp_ready(1'b0);
    check({tag, "_idle_valid"}, {31'b0, ifl.rsp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, ifl.req_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic carry,
                        input logic zero, input logic hold_ready);
    if (hold_ready) set_rsp_ready(1'b1);
    issue_and_wait(tag, op, a, b);
    check_rsp(tag, res, carry, zero);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(1'b0, 2'd0, 32'h0, 32'h0);
    set_rsp_ready(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid",  {31'b0, ifl.rsp_valid}, 32'd0);
    check("rst_req_ready",  {31'b0, ifl.req_ready}, 32'd1);
    check("rst_rsp_result", ifl.rsp_result, 32'h0);
    check("rst_rsp_carry",  {31'b0, ifl.rsp_carry}, 32'd0);
    check("rst_rsp_zero",   {31'b0, ifl.rsp_zero},  32'd0);
    check("rst_alu_cin_l",  {31'b0, la_cin}, 32'd1);
    check("rst_alu_cin_h",  {31'b0, ha_cin}, 32'd0);
    check("rst_alu_mode",   {31'b0, la_mode}, 32'd1);
    rst = 1'b0;

    // ADD / SUB / logic vectors
    run_op("add_c16",  2'd0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 2'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b1);
    run_op("sub_brw",  2'd1, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b1, 1'b0, 1'b0);
    run_op("sub_neg",  2'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq",   2'd1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("and",      2'd2, 32'hF0F0FFFF, 32'h0FF01234, 32'h00F01234, 1'b0, 1'b0, 1'b0);
    run_op("xor",      2'd3, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0);

    // Backpressure: response held 5 cycles, req_valid pulse ignored
    issue_and_wait("bp", 2'd0, 32'h00000005, 32'h00000007);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold%0d_res", i),   ifl.rsp_result, 32'h0000000C);
      check($sformatf("bp_hold%0d_valid", i), {31'b0, ifl.rsp_valid}, 32'd1);
      check($sformatf("bp_hold%0d_ready", i), {31'b0, ifl.req_ready}, 32'd0);
      set_req(i == 2, 2'd0, 32'h00000001, 32'h00000001);
    end
    handshake("bp");
    run_op("bp_next", 2'd0, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 1'b0);

    // Reset while in HI
    @(negedge clk);
    set_req(1'b1, 2'd0, 32'h11111111, 32'h22222222);
    @(posedge clk);          // accept -> LO
    #1;
    set_req(1'b0, 2'd0, 32'h0, 32'h0);
    @(posedge clk);          // -> HI
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstHI_valid_l",  {31'b0, ifl.rsp_valid}, 32'd0);
    check("rstHI_ready_l",  {31'b0, ifl.req_ready}, 32'd1);
    check("rstHI_ready_h",  {31'b0, ifh.req_ready}, 32'd1);
    check("rstHI_result_l", ifl.rsp_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rstHI_noresp%0d", i), {31'b0, ifl.rsp_valid | ifh.rsp_valid}, 32'd0);
    end
    run_op("post_rst", 2'd0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
